popcnt_accum: RTL and testbench

// Streaming population-count accumulator, the stage directly downstream of the (m,k)-counter Cnt.

---
 rtl/popcnt_accum.sv | 181 ++++++++++++++++++
 tb/tb_popcnt_accum.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/popcnt_accum.sv
// Streaming popcount accumulator: per-word set-bit count summed over a frame,
// one saturating {count, words, ovf} result per frame over valid/ready.

package lau_pkg;
    typedef enum logic {SLOW = 1'b0, FAST = 1'b1} speed_e;
endpackage

// (m,k)-counter: combinational number of set bits in a depth-bit word.
module Cnt #(
    parameter int              depth = 18,
    parameter lau_pkg::speed_e speed = lau_pkg::FAST,
    localparam int             CW    = $clog2(depth + 1)
) (
    input  logic [depth-1:0] data_i,
    output logic [CW-1:0]    cnt_o
);
    localparam int DP = depth + (depth % 2);

    logic [DP-1:0] pad;
    assign pad = DP'(data_i);

    if (speed == lau_pkg::FAST) begin : g_fast
        // Sum 2-bit partial counts to shorten the add chain.
        always_comb begin
            cnt_o = '0;
            for (int i = 0; i < DP; i += 2) begin
                cnt_o = cnt_o + CW'({1'b0, pad[i]} + {1'b0, pad[i+1]});
            end
        end
    end else begin : g_slow
        // Plain bit-serial ripple count.
        always_comb begin
            cnt_o = '0;
            for (int i = 0; i < DP; i++) begin
                cnt_o = cnt_o + CW'(pad[i]);
            end
        end
    end
endmodule

module popcnt_accum #(
    parameter int              depth     = 18,
    parameter lau_pkg::speed_e speed     = lau_pkg::FAST,
    parameter int              accWidth  = 16,
    parameter int              wcntWidth = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [depth-1:0]     in_data_i,
    input  logic                 in_last_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [accWidth-1:0]  out_count_o,
    output logic [wcntWidth-1:0] out_words_o,
    output logic                 out_ovf_o
);
    localparam int CW = $clog2(depth + 1);
    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [CW-1:0]        word_cnt;
    logic                 s1_valid_q, s1_valid_d;
    logic [CW-1:0]        s1_cnt_q, s1_cnt_d;
    logic                 s1_last_q, s1_last_d;
    logic [accWidth-1:0]  acc_q, acc_d;
    logic [wcntWidth-1:0] wcnt_q, wcnt_d;
    logic                 ovf_q, ovf_d;
    logic [0:0]           state_q, state_d;
    logic [accWidth-1:0]  cnt_res_q, cnt_res_d;
    logic [wcntWidth-1:0] wrd_res_q, wrd_res_d;
    logic                 ovf_res_q, ovf_res_d;

    logic                 s1_adv, hs;
    logic [accWidth:0]    acc_sum;
    logic [wcntWidth:0]   wcnt_sum;
    logic [accWidth-1:0]  acc_sat;
    logic [wcntWidth-1:0] wcnt_sat;
    logic                 ovf_new;

    Cnt #(.depth(depth), .speed(speed)) u_cnt (
        .data_i(in_data_i),
        .cnt_o (word_cnt)
    );

    assign out_valid_o = (state_q == FULL);
    assign out_count_o = cnt_res_q;
    assign out_words_o = wrd_res_q;
    assign out_ovf_o   = ovf_res_q;

    // Handshake, stall and saturating-add datapath.
    always_comb begin
        s1_adv = s1_valid_q
              && !(s1_last_q && out_valid_o && !out_ready_i);
        in_ready_o = rst_ni && !clear_i
                  && (!s1_valid_q || s1_adv);
        hs = in_valid_i && in_ready_o;
        acc_sum = {1'b0, acc_q} + (accWidth+1)'(s1_cnt_q);
        wcnt_sum = {1'b0, wcnt_q} + 1'b1;
        acc_sat = acc_sum[accWidth] ? '1 : acc_sum[accWidth-1:0];
        wcnt_sat = wcnt_sum[wcntWidth] ? '1 : wcnt_sum[wcntWidth-1:0];
        ovf_new = ovf_q | acc_sum[accWidth] | wcnt_sum[wcntWidth];
    end

    // Next-state for S1, the frame accumulator and the result FSM.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_cnt_d   = s1_cnt_q;
        s1_last_d  = s1_last_q;
        acc_d      = acc_q;
        wcnt_d     = wcnt_q;
        ovf_d      = ovf_q;
        state_d    = state_q;
        cnt_res_d  = cnt_res_q;
        wrd_res_d  = wrd_res_q;
        ovf_res_d  = ovf_res_q;
        if (clear_i) begin
            s1_valid_d = 1'b0;
            acc_d      = '0;
            wcnt_d     = '0;
            ovf_d      = 1'b0;
            state_d    = EMPTY;
            cnt_res_d  = '0;
            wrd_res_d  = '0;
            ovf_res_d  = 1'b0;
        end else begin
            if (hs) begin
                s1_valid_d = 1'b1;
                s1_cnt_d   = word_cnt;
                s1_last_d  = in_last_i;
            end else if (s1_adv) begin
                s1_valid_d = 1'b0;
            end
            if (out_valid_o && out_ready_i) begin
                state_d = EMPTY;
            end
            if (s1_adv && !s1_last_q) begin
                acc_d  = acc_sat;
                wcnt_d = wcnt_sat;
                ovf_d  = ovf_new;
            end else if (s1_adv) begin
                acc_d     = '0;
                wcnt_d    = '0;
                ovf_d     = 1'b0;
                state_d   = FULL;
                cnt_res_d = acc_sat;
                wrd_res_d = wcnt_sat;
                ovf_res_d = ovf_new;
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_cnt_q   <= '0;
            s1_last_q  <= 1'b0;
            acc_q      <= '0;
            wcnt_q     <= '0;
            ovf_q      <= 1'b0;
            state_q    <= EMPTY;
            cnt_res_q  <= '0;
            wrd_res_q  <= '0;
            ovf_res_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_cnt_q   <= s1_cnt_d;
            s1_last_q  <= s1_last_d;
            acc_q      <= acc_d;
            wcnt_q     <= wcnt_d;
            ovf_q      <= ovf_d;
            state_q    <= state_d;
            cnt_res_q  <= cnt_res_d;
            wrd_res_q  <= wrd_res_d;
            ovf_res_q  <= ovf_res_d;
        end
    end
endmodule

// File: tb/tb_popcnt_accum.sv
// Directed bench for popcnt_accum: default instance plus an
// accWidth=6 instance sharing the same input stream.

module tb_popcnt_accum;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [17:0] in_data;
    logic        in_last;
    logic        out_ready;
    logic        out_valid;
    logic [15:0] out_count;
    logic [7:0]  out_words;
    logic        out_ovf;
    logic        in_ready6;
    logic        out_valid6;
    logic [5:0]  out_count6;
    logic [7:0]  out_words6;
    logic        out_ovf6;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    popcnt_accum dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .clear_i    (clear),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (in_data),
        .in_last_i  (in_last),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_count_o(out_count),
        .out_words_o(out_words),
        .out_ovf_o  (out_ovf)
    );

    popcnt_accum #(.accWidth(6)) dut6 (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .clear_i    (clear),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready6),
        .in_data_i  (in_data),
        .in_last_i  (in_last),
        .out_valid_o(out_valid6),
        .out_ready_i(out_ready),
        .out_count_o(out_count6),
        .out_words_o(out_words6),
        .out_ovf_o  (out_ovf6)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic push(input logic [17:0] d, input logic l);
        bit ok = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        for (int i = 0; i < 40 && !ok; i++) begin
            #1;
            if (in_ready) ok = 1;
            @(negedge clk);
        end
        check("push_accepted", 32'(ok), 32'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_res(input string tag,
                              input logic [15:0] c,
                              input logic [7:0] w,
                              input logic o);
        bit seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (out_valid) seen = 1;
            else @(negedge clk);
        end
        check({tag, "_valid"}, 32'(seen), 32'd1);
        check({tag, "_count"}, 32'(out_count), 32'(c));
        check({tag, "_words"}, 32'(out_words), 32'(w));
        check({tag, "_ovf"}, 32'(out_ovf), 32'(o));
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0;
        in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(out_count), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", 32'(in_ready), 32'd1);

        // Basic 3-word frame, exact timing.
        push(18'h3FFFF, 1'b0);
        push(18'h00001, 1'b0);
        push(18'h15555, 1'b1);
        check("f1_not_yet", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("f1_valid", 32'(out_valid), 32'd1);
        check("f1_count", 32'(out_count), 32'd28);
        check("f1_words", 32'(out_words), 32'd3);
        check("f1_ovf", 32'(out_ovf), 32'd0);
        @(negedge clk);
        check("f1_one_cycle", 32'(out_valid), 32'd0);

        // Back-to-back single-word frames.
        in_valid = 1'b1; in_data = 18'h3FFFF; in_last = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            check("b2b_ready", 32'(in_ready), 32'd1);
            if (c >= 2) begin
                check("b2b_valid", 32'(out_valid), 32'd1);
                check("b2b_count", 32'(out_count), 32'd18);
                check("b2b_words", 32'(out_words), 32'd1);
            end
        end
        in_valid = 1'b0; in_last = 1'b0;
        repeat (3) @(negedge clk);
        check("b2b_drained", 32'(out_valid), 32'd0);

        // Backpressure: two frames held, then drained in order.
        out_ready = 1'b0;
        push(18'h0000F, 1'b1);
        push(18'h000FF, 1'b1);
        #1;
        check("bp_ready_low", 32'(in_ready), 32'd0);
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_count_a", 32'(out_count), 32'd4);
        repeat (3) @(negedge clk);
        check("bp_hold_count", 32'(out_count), 32'd4);
        check("bp_hold_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        #1;
        check("bp_ready_up", 32'(in_ready), 32'd1);
        @(negedge clk);
        check("bp_valid_b", 32'(out_valid), 32'd1);
        check("bp_count_b", 32'(out_count), 32'd8);
        @(negedge clk);
        check("bp_empty", 32'(out_valid), 32'd0);

        // Saturation in the narrow instance.
        push(18'h3FFFF, 1'b0);
        push(18'h3FFFF, 1'b0);
        push(18'h3FFFF, 1'b0);
        push(18'h3FFFF, 1'b1);
        @(negedge clk);
        check("sat6_valid", 32'(out_valid6), 32'd1);
        check("sat6_count", 32'(out_count6), 32'd63);
        check("sat6_words", 32'(out_words6), 32'd4);
        check("sat6_ovf", 32'(out_ovf6), 32'd1);
        check("sat16_count", 32'(out_count), 32'd72);
        check("sat16_ovf", 32'(out_ovf), 32'd0);
        @(negedge clk);
        push(18'h00003, 1'b1);
        @(negedge clk);
        check("sat6_next_count", 32'(out_count6), 32'd2);
        check("sat6_next_ovf", 32'(out_ovf6), 32'd0);

        // clear_i aborts a partial frame.
        @(negedge clk);
        push(18'h3FFFF, 1'b0);
        push(18'h3FFFF, 1'b0);
        clear = 1'b1;
        #1;
        check("clr_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        clear = 1'b0;
        check("clr_no_res", 32'(out_valid), 32'd0);
        push(18'h00007, 1'b1);
        expect_res("clr", 16'd3, 8'd1, 1'b0);

        // Reset mid-frame discards earlier words.
        push(18'h3FFFF, 1'b0);
        push(18'h000FF, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mrst_ready", 32'(in_ready), 32'd0);
        check("mrst_valid", 32'(out_valid), 32'd0);
        check("mrst_words", 32'(out_words), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push(18'h00003, 1'b1);
        expect_res("mrst", 16'd2, 8'd1, 1'b0);

        // All-zero word counts as a word, adds nothing.
        push(18'h00000, 1'b0);
        push(18'h00100, 1'b1);
        expect_res("zero", 16'd1, 8'd2, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
